and22_rr_arb: RTL and testbench

AND22_RR_ARB -- requirements
Module: and22_rr_arb

---
 rtl/and22_arb_pkg.sv | 15 +
 rtl/and22.sv | 13 +
 rtl/and22_rr_arb.sv | 106 ++++++++++
 tb/tb_and22_rr_arb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/and22_arb_pkg.sv
// and22_arb_pkg: shared slot-state enum and requester IDs for the and22 round-robin arbiter.
// Contents:
//   slot_e       - result slot state (EMPTY, FULL)
//   REQ0 / REQ1  - requester index constants used for res_id and the last-grant pointer
package and22_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/and22.sv
// and22: 2-bit bitwise AND datapath.
// Ports:
//   a, b - 2-bit operands
//   z    - a & b
module and22 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] z
);

    assign z = a & b;

endmodule

// File: rtl/and22_rr_arb.sv
// and22_rr_arb: two requesters share one and22 datapath through a round-robin grant and a one-entry result slot.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   reqX_valid/reqX_a/reqX_b        - requester X operand pair (X = 0, 1)
//   reqX_ready                      - requester X pair accepted this cycle
//   res_valid/res_z/res_id          - result slot contents (a & b and producing requester)
//   res_ready                       - consumer accepts the result
//   gnt_cnt0/gnt_cnt1               - saturating per-requester accept counters (only with AND22_ARB_STATS_EN)
// Build option: define AND22_ARB_STATS_EN to add the grant counters and their ports.
module and22_rr_arb
    import and22_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [1:0]       req0_a,
    input  logic [1:0]       req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_a,
    input  logic [1:0]       req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [1:0]       res_z,
    output logic             res_id,
    input  logic             res_ready
`ifdef AND22_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    slot_e      state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] z_q, z_d;
    logic       id_q, id_d;
    logic       slot_free;
    logic       gnt1;
    logic       accept;
    logic [1:0] mux_a, mux_b, and_z;

    and22 u_and22 (
        .a(mux_a),
        .b(mux_b),
        .z(and_z)
    );

    always_comb begin
        // A FULL slot is free exactly when it drains this cycle; res_valid mirrors FULL,
        // so only res_ready enters the ready path combinationally.
        slot_free  = (state_q == EMPTY) || res_ready;
        // Requester 1 wins when it is alone, or when both contend and requester 0 had the last accept.
        gnt1       = req1_valid && (!req0_valid || (last_q == REQ0));
        req1_ready = rst_n && slot_free && gnt1;
        req0_ready = rst_n && slot_free && req0_valid && !gnt1;
        accept     = req0_ready || req1_ready;
        mux_a      = gnt1 ? req1_a : req0_a;
        mux_b      = gnt1 ? req1_b : req0_b;
        state_d    = accept ? FULL : (res_ready ? EMPTY : state_q);
        last_d     = accept ? (req1_ready ? REQ1 : REQ0) : last_q;
        z_d        = accept ? and_z : z_q;
        id_d       = accept ? (req1_ready ? REQ1 : REQ0) : id_q;
        res_valid  = (state_q == FULL);
        res_z      = z_q;
        res_id     = id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            last_q  <= REQ1;
            z_q     <= 2'b00;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            z_q     <= z_d;
            id_q    <= id_d;
        end
    end

`ifdef AND22_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d   = (req0_ready && (cnt0_q != '1)) ? cnt0_q + 1'b1 : cnt0_q;
        cnt1_d   = (req1_ready && (cnt1_q != '1)) ? cnt1_q + 1'b1 : cnt1_q;
        gnt_cnt0 = cnt0_q;
        gnt_cnt1 = cnt1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
`endif

endmodule

// File: tb/tb_and22_rr_arb.sv
// tb_and22_rr_arb: directed vector table, hand sequences and randomized traffic against a queue-based reference model.
module tb_and22_rr_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
    logic [1:0] req0_a = 2'b00, req0_b = 2'b00, req1_a = 2'b00, req1_b = 2'b00;
    logic       req0_ready, req1_ready, res_valid, res_id;
    logic [1:0] res_z;
`ifdef AND22_ARB_STATS_EN
    logic [1:0] gnt_cnt0, gnt_cnt1;
`endif

    int n_pass = 0;
    int n_total = 0;

    // Reference model: the result slot as a queue of {id, z}, plus the requester of the last accept.
    logic [2:0] m_q[$];
    int         m_last = 1;

    always #5 clk = ~clk;

    and22_rr_arb #(.CNT_W(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0_valid(req0_valid),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .req1_ready(req1_ready),
        .res_valid(res_valid),
        .res_z(res_z),
        .res_id(res_id),
        .res_ready(res_ready)
`ifdef AND22_ARB_STATS_EN
        ,
        .gnt_cnt0(gnt_cnt0),
        .gnt_cnt1(gnt_cnt1)
`endif
    );

    typedef struct {
        logic       v0;
        logic [1:0] a0, b0;
        logic       v1;
        logic [1:0] a1, b1;
        logic       rr;
        logic       r0, r1, rv;
        logic [1:0] z;
        logic       id;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic drive(input logic v0, input logic [1:0] a0, input logic [1:0] b0,
                         input logic v1, input logic [1:0] a1, input logic [1:0] b1, input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 2'b11, 2'b11, 1'b1, 2'b11, 2'b11, 1'b1);
        #1;
        chk("rst_res_valid", {7'b0, res_valid}, 8'd0);
        chk("rst_ready0", {7'b0, req0_ready}, 8'd0);
        chk("rst_ready1", {7'b0, req1_ready}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        m_q.delete();
        m_last = 1;
    endtask

    task automatic step(input logic v0, input logic [1:0] a0, input logic [1:0] b0,
                        input logic v1, input logic [1:0] a1, input logic [1:0] b1, input logic rr);
        logic       free, g1, e0, e1;
        logic [2:0] head;
        drive(v0, a0, b0, v1, a1, b1, rr);
        #1;
        free = (m_q.size() == 0) || rr;
        g1   = v1 && (!v0 || m_last == 0);
        e1   = free && g1;
        e0   = free && v0 && !g1;
        chk("m_ready0", {7'b0, req0_ready}, {7'b0, e0});
        chk("m_ready1", {7'b0, req1_ready}, {7'b0, e1});
        chk("m_res_valid", {7'b0, res_valid}, {7'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk("m_res_z", {6'b0, res_z}, {6'b0, head[1:0]});
            chk("m_res_id", {7'b0, res_id}, {7'b0, head[2]});
        end
        @(posedge clk);
        #1;
        if (m_q.size() != 0 && rr) void'(m_q.pop_front());
        if (e0) begin m_q.push_back({1'b0, a0 & b0}); m_last = 0; end
        if (e1) begin m_q.push_back({1'b1, a1 & b1}); m_last = 1; end
    endtask

    initial begin
        // Contention from reset, single requester, then backpressure with 2'b01 held.
        tbl[0]  = '{1, 2'b11, 2'b01, 1, 2'b10, 2'b11, 1, 1, 0, 0, 2'b00, 0};
        tbl[1]  = '{1, 2'b11, 2'b01, 1, 2'b10, 2'b11, 1, 0, 1, 1, 2'b01, 0};
        tbl[2]  = '{1, 2'b11, 2'b01, 1, 2'b10, 2'b11, 1, 1, 0, 1, 2'b10, 1};
        tbl[3]  = '{1, 2'b11, 2'b01, 1, 2'b10, 2'b11, 1, 0, 1, 1, 2'b01, 0};
        tbl[4]  = '{0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 1, 2'b10, 1};
        tbl[5]  = '{1, 2'b11, 2'b10, 0, 2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 0};
        tbl[6]  = '{1, 2'b01, 2'b11, 0, 2'b00, 2'b00, 1, 1, 0, 1, 2'b10, 0};
        tbl[7]  = '{0, 2'b00, 2'b00, 1, 2'b11, 2'b11, 0, 0, 0, 1, 2'b01, 0};
        tbl[8]  = '{0, 2'b00, 2'b00, 1, 2'b11, 2'b11, 0, 0, 0, 1, 2'b01, 0};
        tbl[9]  = '{0, 2'b00, 2'b00, 1, 2'b11, 2'b11, 1, 0, 1, 1, 2'b01, 0};
        tbl[10] = '{0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 1, 2'b11, 1};
        tbl[11] = '{0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00, 0};

        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
            #1;
            chk($sformatf("t%0d_ready0", i), {7'b0, req0_ready}, {7'b0, tbl[i].r0});
            chk($sformatf("t%0d_ready1", i), {7'b0, req1_ready}, {7'b0, tbl[i].r1});
            chk($sformatf("t%0d_res_valid", i), {7'b0, res_valid}, {7'b0, tbl[i].rv});
            if (tbl[i].rv) begin
                chk($sformatf("t%0d_res_z", i), {6'b0, res_z}, {6'b0, tbl[i].z});
                chk($sformatf("t%0d_res_id", i), {7'b0, res_id}, {7'b0, tbl[i].id});
            end
            @(posedge clk);
            #1;
        end

        // Exhaustive operand sweep through requester 0.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ab;
            ab = i[3:0];
            step(1'b1, ab[3:2], ab[1:0], 1'b0, 2'b00, 2'b00, 1'b1);
        end
        step(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        // Reset asserted while the slot is FULL.
        drive(1'b1, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        chk("mr_full", {7'b0, res_valid}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_res_valid", {7'b0, res_valid}, 8'd0);
        chk("mr_async_ready0", {7'b0, req0_ready}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
        m_q.delete();
        m_last = 1;
        #1;
        chk("mr_no_replay", {7'b0, res_valid}, 8'd0);
        drive(1'b1, 2'b10, 2'b10, 1'b1, 2'b01, 2'b01, 1'b1);
        #1;
        chk("mr_first_gnt0", {7'b0, req0_ready}, 8'd1);
        chk("mr_first_gnt1", {7'b0, req1_ready}, 8'd0);
        step(1'b1, 2'b10, 2'b10, 1'b1, 2'b01, 2'b01, 1'b1);
        step(1'b1, 2'b10, 2'b10, 1'b1, 2'b01, 2'b01, 1'b1);
        step(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);

`ifdef AND22_ARB_STATS_EN
        // Saturation of a 2-bit counter after five accepts.
        do_reset();
        chk("st_rst_cnt0", {6'b0, gnt_cnt0}, 8'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1);
        step(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
        chk("st_cnt0_sat", {6'b0, gnt_cnt0}, 8'd3);
        chk("st_cnt1_zero", {6'b0, gnt_cnt1}, 8'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
